// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM transmit sequencer and receive demux.
// Frame geometry, default sizing and the receive-side alignment state encoding.
// Optional macro TDM_DEMUX_PARITY_EN adds one even-parity beat per frame.
package tdm_pkg;

    // Frame-alignment states of the receiver.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } tdm_state_e;

    localparam int TDM_N_SLOTS     = 4;
`ifdef TDM_DEMUX_PARITY_EN
    // Counter must reach N_SLOTS to address the trailing parity beat.
    localparam int TDM_SLOT_W      = 3;
`else
    localparam int TDM_SLOT_W      = 2;
`endif
    localparam int TDM_LOCK_FRAMES = 2;

    // Number of enabled beats making up one frame.
    function automatic int tdm_frame_beats(input int n_slots);
`ifdef TDM_DEMUX_PARITY_EN
        return n_slots + 1;
`else
        return n_slots;
`endif
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter for the TDM receiver.
// Counts enabled beats, wraps at the terminal count, and can be cleared to 0
// (lost alignment) or loaded with 1 (a strobe just realigned slot 0).
module tdm_slot_counter #(
    parameter int SLOT_W = 2,
    parameter int TC     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              load1_i,
    output logic [SLOT_W-1:0] cnt_o
);

    localparam logic [SLOT_W-1:0] TC_V = SLOT_W'(TC);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    // Next count: clear beats realign, realign beats advance, advance wraps.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = SLOT_W'(1);
        end else if (en_i) begin
            cnt_d = (cnt_q == TC_V) ? '0 : cnt_q + SLOT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking updates so all flops sample pre-edge values together.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM serial-to-parallel receiver with frame-strobe alignment.
// Hunts for the slot-0 strobe, confirms LOCK_FRAMES aligned strobes, then
// rebuilds each frame into a registered word y with a one-cycle y_valid.
// Optional macro TDM_DEMUX_PARITY_EN appends an even-parity beat and par_err.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int N_SLOTS     = TDM_N_SLOTS,
    parameter int SLOT_W      = TDM_SLOT_W,
    parameter int LOCK_FRAMES = TDM_LOCK_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               din,
    input  logic               frame,
    output logic [N_SLOTS-1:0] y,
    output logic               y_valid,
    output logic [SLOT_W-1:0]  slot,
    output logic               locked,
    output logic               sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    output logic               par_err
`endif
);

    // Headroom of one above LOCK_FRAMES so good+1 never wraps.
    localparam int                GOOD_W    = $clog2(LOCK_FRAMES + 2);
    localparam int                LAST_IDX  = tdm_frame_beats(N_SLOTS) - 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LAST_IDX);
    localparam logic [GOOD_W-1:0] LOCK_CNT  = GOOD_W'(LOCK_FRAMES);

    tdm_state_e         state_q, state_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [N_SLOTS-1:0] shadow_q, shadow_d;
    logic [N_SLOTS-1:0] y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               sync_err_q, sync_err_d;
    logic               locked_q, locked_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic               par_err_q, par_err_d;
`endif
    logic [SLOT_W-1:0]  slot_q;
    logic               cnt_adv, cnt_clr, cnt_load1;
    logic               sh_wr, sh_realign, err;

    tdm_slot_counter #(
        .SLOT_W (SLOT_W),
        .TC     (LAST_IDX)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (cnt_adv),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .cnt_o   (slot_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_HUNT;
        else        state_q <= state_d;
    end

    // Next-state and alignment control: one decision per enabled beat.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        cnt_adv    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load1  = 1'b0;
        sh_wr      = 1'b0;
        sh_realign = 1'b0;
        err        = 1'b0;
        if (en) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame) begin
                        cnt_load1  = 1'b1;
                        sh_realign = 1'b1;
                        good_d     = GOOD_W'(1);
                        state_d    = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                default: begin
                    if (slot_q == '0) begin
                        if (frame) begin
                            cnt_adv = 1'b1;
                            sh_wr   = 1'b1;
                            if (state_q == ST_CHECK) begin
                                good_d = good_q + GOOD_W'(1);
                                if (good_d >= LOCK_CNT) state_d = ST_LOCKED;
                            end
                        end else begin
                            // Strobe missing where slot 0 was expected.
                            err     = 1'b1;
                            cnt_clr = 1'b1;
                            good_d  = '0;
                            state_d = ST_HUNT;
                        end
                    end else if (frame) begin
                        // Strobe arrived early: this beat becomes slot 0.
                        err        = 1'b1;
                        cnt_load1  = 1'b1;
                        sh_realign = 1'b1;
                        good_d     = GOOD_W'(1);
                        state_d    = ST_CHECK;
                    end else begin
                        cnt_adv = 1'b1;
                        sh_wr   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Shadow update: realign writes slot 0, normal beats write the current slot.
    always_comb begin
        shadow_d = shadow_q;
        if (sh_realign) begin
            shadow_d[0] = din;
        end else if (sh_wr) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (slot_q == SLOT_W'(i)) shadow_d[i] = din;
            end
        end
    end

    // Output decode: publish the word on the final beat of a locked frame.
    always_comb begin
        y_d        = y_q;
        y_valid_d  = 1'b0;
        sync_err_d = err;
        locked_d   = (state_d == ST_LOCKED);
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d  = 1'b0;
`endif
        if (en && state_q == ST_LOCKED && slot_q == LAST_SLOT && !frame) begin
`ifdef TDM_DEMUX_PARITY_EN
            if ((^shadow_q) == din) begin
                y_d       = shadow_q;
                y_valid_d = 1'b1;
            end else begin
                par_err_d = 1'b1;
            end
`else
            y_d       = shadow_d;
            y_valid_d = 1'b1;
`endif
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q     <= '0;
            // NOTE: shadow is a small register file cleared on reset so a partial
            // frame never leaks stale bits into the first word after reset.
            shadow_q   <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            good_q     <= good_d;
            shadow_q   <= shadow_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            sync_err_q <= sync_err_d;
            locked_q   <= locked_d;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Parity error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    assign par_err  = par_err_q;
`endif

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign slot     = slot_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4.
// Default build exercises lock, enable gaps, early/missing/late strobes and
// reset mid-frame; with TDM_DEMUX_PARITY_EN it exercises the parity beat.
module tb_tdm_demux4;
    import tdm_pkg::*;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  en    = 1'b0;
    logic                  din   = 1'b0;
    logic                  frame = 1'b0;
    logic [3:0]            y;
    logic                  y_valid;
    logic [TDM_SLOT_W-1:0] slot;
    logic                  locked;
    logic                  sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic                  par_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int nv;
    logic l0;

    always #5 clk = ~clk;

    tdm_demux4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .din      (din),
        .frame    (frame),
        .y        (y),
        .y_valid  (y_valid),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs are stable 1 time unit later.
    task automatic beat(input logic e, input logic d, input logic f);
        en    = e;
        din   = d;
        frame = f;
        @(posedge clk);
        #1;
    endtask

    // Four data beats (bit i in slot i); optional 2-cycle en=0 gaps between beats.
    task automatic send_frame(input logic [3:0] bits, input logic strobe, input bit gaps,
                              output int nvalid, output logic lock0);
        nvalid = 0;
        lock0  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, bits[i], (i == 0) ? strobe : 1'b0);
            if (y_valid) nvalid++;
            if (i == 0) lock0 = locked;
            if (gaps && i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    beat(1'b0, ~bits[i], 1'b1);
                    check("gap_slot", 32'(slot), 32'(i + 1));
                    check("gap_valid", 32'(y_valid), 32'd0);
                end
            end
        end
`ifdef TDM_DEMUX_PARITY_EN
        beat(1'b1, 1'b0, 1'b0);
`endif
    endtask

`ifdef TDM_DEMUX_PARITY_EN
    task automatic send_pframe(input logic [3:0] bits, input logic par);
        for (int i = 0; i < 4; i++) beat(1'b1, bits[i], (i == 0) ? 1'b1 : 1'b0);
        beat(1'b1, par, 1'b0);
    endtask
`endif

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_y", 32'(y), 32'd0);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
`ifdef TDM_DEMUX_PARITY_EN
        check("rst_par_err", 32'(par_err), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
        // Data 1,1,0,0 with correct even parity 0.
        send_pframe(4'b0011, 1'b0);
        check("p_first_locked", 32'(locked), 32'd0);
        send_pframe(4'b0011, 1'b0);
        check("p_ok_y", 32'(y), 32'h3);
        check("p_ok_valid", 32'(y_valid), 32'd1);
        check("p_ok_par_err", 32'(par_err), 32'd0);
        // Wrong parity: word held, error pulse, lock kept.
        send_pframe(4'b0101, 1'b1);
        check("p_bad_par_err", 32'(par_err), 32'd1);
        check("p_bad_valid", 32'(y_valid), 32'd0);
        check("p_bad_y", 32'(y), 32'h3);
        check("p_bad_locked", 32'(locked), 32'd1);
        // Odd-weight data with parity 1 is accepted.
        send_pframe(4'b0111, 1'b1);
        check("p_ok2_y", 32'(y), 32'h7);
        check("p_ok2_valid", 32'(y_valid), 32'd1);
        check("p_ok2_par_err", 32'(par_err), 32'd0);
`else
        // Lock: first strobe enters CHECK only.
        send_frame(4'b0101, 1'b1, 1'b0, nv, l0);
        check("lock1_locked", 32'(locked), 32'd0);
        check("lock1_slot", 32'(slot), 32'd0);
        check("lock1_nvalid", 32'(nv), 32'd0);
        // Second strobe locks; this frame is the first output frame.
        send_frame(4'b0101, 1'b1, 1'b0, nv, l0);
        check("lock2_locked_at_strobe", 32'(l0), 32'd1);
        check("lock2_y", 32'(y), 32'h5);
        check("lock2_valid", 32'(y_valid), 32'd1);
        check("lock2_nvalid", 32'(nv), 32'd1);
        send_frame(4'b1110, 1'b1, 1'b0, nv, l0);
        check("frame3_y", 32'(y), 32'hE);
        check("frame3_nvalid", 32'(nv), 32'd1);

        // Enable gaps give the same words, one valid per frame.
        send_frame(4'b0101, 1'b1, 1'b1, nv, l0);
        check("gapA_y", 32'(y), 32'h5);
        check("gapA_nvalid", 32'(nv), 32'd1);
        send_frame(4'b1110, 1'b1, 1'b1, nv, l0);
        check("gapB_y", 32'(y), 32'hE);
        check("gapB_nvalid", 32'(nv), 32'd1);

        // Early strobe at slot 2.
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        check("early_sync_err", 32'(sync_err), 32'd1);
        check("early_locked", 32'(locked), 32'd0);
        check("early_slot", 32'(slot), 32'd1);
        check("early_y", 32'(y), 32'hE);
        check("early_valid", 32'(y_valid), 32'd0);
        beat(1'b1, 1'b0, 1'b0);
        check("early_err_pulse", 32'(sync_err), 32'd0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        check("early_partial_valid", 32'(y_valid), 32'd0);
        check("early_partial_y", 32'(y), 32'hE);
        send_frame(4'b1001, 1'b1, 1'b0, nv, l0);
        check("early_relock", 32'(l0), 32'd1);
        check("early_relock_y", 32'(y), 32'h9);
        check("early_relock_nvalid", 32'(nv), 32'd1);

        // Missing strobe at slot 0.
        beat(1'b1, 1'b0, 1'b0);
        check("miss_sync_err", 32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_slot", 32'(slot), 32'd0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        check("miss_hunt_slot", 32'(slot), 32'd0);
        check("miss_hunt_valid", 32'(y_valid), 32'd0);
        check("miss_hunt_y", 32'(y), 32'h9);
        send_frame(4'b0011, 1'b1, 1'b0, nv, l0);
        check("miss_one_strobe_locked", 32'(locked), 32'd0);
        check("miss_one_strobe_nvalid", 32'(nv), 32'd0);
        send_frame(4'b0011, 1'b1, 1'b0, nv, l0);
        check("miss_relock", 32'(l0), 32'd1);
        check("miss_relock_y", 32'(y), 32'h3);

        // Strobe on the last slot: wrong-slot error, no word update.
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        check("late_sync_err", 32'(sync_err), 32'd1);
        check("late_valid", 32'(y_valid), 32'd0);
        check("late_y", 32'(y), 32'h3);
        check("late_slot", 32'(slot), 32'd1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b1, 1'b0, nv, l0);
        check("late_relock", 32'(l0), 32'd1);
        check("late_relock_y", 32'(y), 32'h6);

        // Reset mid-frame at slot 2, checked before the next clock edge.
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        check("pre_rst_slot", 32'(slot), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_slot", 32'(slot), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(4'b0101, 1'b1, 1'b0, nv, l0);
        check("post_rst_locked", 32'(locked), 32'd0);
        check("post_rst_nvalid", 32'(nv), 32'd0);
        send_frame(4'b0101, 1'b1, 1'b0, nv, l0);
        check("post_rst_relock", 32'(l0), 32'd1);
        check("post_rst_y", 32'(y), 32'h5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
